// File: rtl/audio_lookup_table.sv
// Address -> 16-bit signed PCM sample for a 3-tone clip (250/500/1000 Hz), one registered stage, no handshake.
// Optional linear fade-out over the final 256 samples when AUDIO_LUT_FADE_EN is defined.
module audio_lookup_table #(
  parameter int CLIP_LENGTH    = 48000,
  parameter int SEGMENT_LENGTH = 16000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  output logic [15:0] data_out,
  output logic        out_of_range
);

  localparam logic [16:0] SEG1_END = 17'(SEGMENT_LENGTH);
  localparam logic [16:0] SEG2_END = 17'(2 * SEGMENT_LENGTH);
  localparam logic [16:0] CLIP_END = 17'(CLIP_LENGTH);

  logic [15:0] data_out_d, data_out_q;
  logic        out_of_range_d, out_of_range_q;

  logic [16:0]        addr_ext;
  logic [5:0]         phase;
  logic [4:0]         fold;
  logic [4:0]         q_idx;
  logic [15:0]        mag;
  logic signed [15:0] sine;
  logic               in_range;

  // Quarter-wave: round(32000 * sin(pi*k/32)), k = 0..16
  function automatic logic [14:0] quarter(input logic [4:0] k);
    logic [14:0] v;
    case (k)
      5'd0:    v = 15'd0;
      5'd1:    v = 15'd3137;
      5'd2:    v = 15'd6243;
      5'd3:    v = 15'd9289;
      5'd4:    v = 15'd12246;
      5'd5:    v = 15'd15085;
      5'd6:    v = 15'd17778;
      5'd7:    v = 15'd20301;
      5'd8:    v = 15'd22627;
      5'd9:    v = 15'd24736;
      5'd10:   v = 15'd26607;
      5'd11:   v = 15'd28221;
      5'd12:   v = 15'd29564;
      5'd13:   v = 15'd30622;
      5'd14:   v = 15'd31385;
      5'd15:   v = 15'd31846;
      5'd16:   v = 15'd32000;
      default: v = 15'd0;
    endcase
    return v;
  endfunction

  // Segment starts are multiples of 64, so the raw low address bits give the phase directly.
  always_comb begin
    addr_ext = {1'b0, address};
    in_range = (addr_ext < CLIP_END);
    if (addr_ext < SEG1_END) begin
      phase = address[5:0];
    end else if (addr_ext < SEG2_END) begin
      phase = {address[4:0], 1'b0};
    end else begin
      phase = {address[3:0], 2'b00};
    end
    fold  = phase[4:0];
    q_idx = (fold > 5'd16) ? 5'(6'd32 - {1'b0, fold}) : fold;
    mag   = {1'b0, quarter(q_idx)};
    sine  = phase[5] ? -$signed(mag) : $signed(mag);
  end

`ifdef AUDIO_LUT_FADE_EN
  localparam logic [16:0] FADE_START = 17'(CLIP_LENGTH - 256);

  logic [8:0]         remain;
  logic signed [24:0] prod;
  logic               fade_zone;

  // Remaining samples lie in 1..256, so a 9-bit modular difference is exact.
  always_comb begin
    fade_zone = in_range && (addr_ext >= FADE_START);
    remain    = 9'(CLIP_END[8:0] - address[8:0]);
    prod      = 25'(sine) * 25'(signed'({1'b0, remain}));
    if (!in_range) begin
      data_out_d = 16'd0;
    end else if (fade_zone) begin
      data_out_d = 16'(prod >>> 8);
    end else begin
      data_out_d = sine;
    end
    out_of_range_d = !in_range;
  end
`else
  always_comb begin
    data_out_d     = in_range ? sine : 16'd0;
    out_of_range_d = !in_range;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q     <= 16'd0;
      out_of_range_q <= 1'b0;
    end else begin
      data_out_q     <= data_out_d;
      out_of_range_q <= out_of_range_d;
    end
  end

  assign data_out     = data_out_q;
  assign out_of_range = out_of_range_q;

endmodule

// File: tb/tb_audio_lookup_table.sv
// Bench for audio_lookup_table: constant vector table, sine-model sweeps, reset and mid-stream reset sequences.
module tb_audio_lookup_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        out_of_range;

  audio_lookup_table dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .data_out    (data_out),
    .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        oor;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        oor;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cycle   = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: 32000*sin at the tone frequency (250 Hz * mult at 16 kHz), rounded to nearest.
  function automatic int model(input int a);
    int  mult;
    int  ph;
    int  s;
    real r;
    if (a >= 48000) return 0;
    mult = (a < 16000) ? 1 : ((a < 32000) ? 2 : 4);
    ph   = (a * mult) % 64;
    r    = 32000.0 * $sin(2.0 * 3.14159265358979 * ph / 64.0);
    s    = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
`ifdef AUDIO_LUT_FADE_EN
    if (a >= 48000 - 256) s = (s * (48000 - a)) >>> 8;
`endif
    return s;
  endfunction

  function automatic vec_t mk(input int a, input int d, input bit o);
    vec_t v;
    v.addr = 16'(a);
    v.data = 16'(d);
    v.oor  = o;
    return v;
  endfunction

  task automatic check(input string name, input int addr, input logic [16:0] got, input logic [16:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s addr=%0d got oor=%0b data=%0d expected oor=%0b data=%0d",
               name, addr, got[16], $signed(got[15:0]), exp[16], $signed(exp[15:0]));
    end
  endtask

  // Present address a just after an edge; its result is due after the next edge.
  task automatic drive(input int a, input int d, input bit o);
    exp_t e;
    @(posedge clk);
    #1;
    address = 16'(a);
    e.addr = 16'(a);
    e.data = 16'(d);
    e.oor  = o;
    e.due  = cycle + 1;
    sb.push_back(e);
  endtask

  // Scoreboard checker: samples after the next address is already applied, so a
  // combinational path from address to outputs would show up as a mismatch.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].due <= cycle) begin
        e = sb.pop_front();
        if (e.due == cycle) begin
          check("sample", int'(e.addr), {out_of_range, data_out}, {e.oor, e.data});
        end else begin
          check("stale_expectation", int'(e.addr), 17'(cycle), 17'(e.due));
        end
      end
    end
  end

  vec_t vecs[20];

  initial begin
    int fade_47999;
    int fade_47748;
`ifdef AUDIO_LUT_FADE_EN
    fade_47999 = -48;
    fade_47748 = 31500;
`else
    fade_47999 = -12246;
    fade_47748 = 32000;
`endif
    vecs[0]  = mk(0,      0,          1'b0);
    vecs[1]  = mk(8,      22627,      1'b0);
    vecs[2]  = mk(16,     32000,      1'b0);
    vecs[3]  = mk(48,     -32000,     1'b0);
    vecs[4]  = mk(4,      12246,      1'b0);
    vecs[5]  = mk(24,     22627,      1'b0);
    vecs[6]  = mk(40,     -22627,     1'b0);
    vecs[7]  = mk(16008,  32000,      1'b0);
    vecs[8]  = mk(16024,  -32000,     1'b0);
    vecs[9]  = mk(32004,  32000,      1'b0);
    vecs[10] = mk(32012,  -32000,     1'b0);
    vecs[11] = mk(32002,  22627,      1'b0);
    vecs[12] = mk(15999,  -3137,      1'b0);
    vecs[13] = mk(16000,  0,          1'b0);
    vecs[14] = mk(47999,  fade_47999, 1'b0);
    vecs[15] = mk(48000,  0,          1'b1);
    vecs[16] = mk(65535,  0,          1'b1);
    vecs[17] = mk(0,      0,          1'b0);
    vecs[18] = mk(47748,  fade_47748, 1'b0);
    vecs[19] = mk(47744,  0,          1'b0);

    rst_n   = 1'b1;
    address = 16'd16;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async", 16, {out_of_range, data_out}, 17'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 16, {out_of_range, data_out}, 17'd0);

    // Release between edges; the next edge registers address 16.
    begin
      exp_t e;
      rst_n  = 1'b1;
      e.addr = 16'd16;
      e.data = 16'd32000;
      e.oor  = 1'b0;
      e.due  = cycle + 1;
      sb.push_back(e);
    end

    for (int i = 0; i < 20; i++) begin
      drive(int'(vecs[i].addr), int'($signed(vecs[i].data)), vecs[i].oor);
    end

    for (int p = 0; p < 64; p++) drive(p, model(p), 1'b0);
    for (int k = 0; k < 32; k++) drive(16000 + k, model(16000 + k), 1'b0);
    for (int k = -2; k < 16; k++) drive(32000 + k, model(32000 + k), 1'b0);
    for (int k = 0; k < 4; k++) drive(47996 + k, model(47996 + k), 1'b0);

    // Mid-stream reset pulse between edges while streaming 0..100.
    for (int a = 0; a <= 100; a++) begin
      drive(a, model(a), 1'b0);
      if (a == 50) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset", a, {out_of_range, data_out}, 17'd0);
        rst_n = 1'b1;
      end
    end

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", 0, 17'(sb.size()), 17'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_lookup_table.md
# audio_lookup_table

Synchronous, procedurally generated sample source for the 3-second audio clip. It maps a 16-bit sample address (0..47999 at 16 kHz) to a 16-bit two's-complement PCM sample, with one clock of latency. The clip is three 1-second sine tones (250 Hz, 500 Hz, 1 kHz) synthesised from a quarter-wave table. It sits behind `audio_player`, which drives `address` from its sample counter and uses `data_out[15:12]` for PWM.

## Interface
- `CLIP_LENGTH`, default 48000: number of valid addresses. Addresses at or above this value are silent.
- `SEGMENT_LENGTH`, default 16000: samples per tone segment. Must be a multiple of 64.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `address`  in  16  sample index.
- `data_out`  out  16  registered signed PCM sample.
- `out_of_range`  out  1  registered; 1 when the sampled address ≥ `CLIP_LENGTH`.

## Operation
- Quarter-wave table Q[k], k = 0..16: Q[k] = round(32000·sin(π·k/32)). Fixed constants.
  - Checkpoints: Q[0] = 0, Q[8] = 22627, Q[16] = 32000.
- Full-wave lookup S(p), for phase p in 0..63:
  - p 0..16: Q[p]
  - p 17..31: Q[32−p]
  - p 32..48: −Q[p−32]
  - p 49..63: −Q[64−p]
- Segment selection, with a = `address`:
  - Segment 0, a < `SEGMENT_LENGTH`: p = a mod 64 (250 Hz).
  - Segment 1, a < 2·`SEGMENT_LENGTH`: p = (a mod 32)·2 (500 Hz).
  - Segment 2, a < `CLIP_LENGTH`: p = (a mod 16)·4 (1 kHz).
  - a ≥ `CLIP_LENGTH`: sample = 0, `out_of_range` = 1.
- Because segment starts are multiples of 64, each segment begins at phase 0. Moduli are taken on the raw address (low bits).
- Negation is 16-bit two's complement. Peak values are ±32000, so there is no overflow.
- Only the segment compare needs wide logic; phase is derived from `address[5:0]`.

## Timing
- Reset (`rst_n` low, asynchronous): `data_out` = 0x0000 and `out_of_range` = 0 immediately. Both hold until the first rising edge after release.
- Latency: `address` sampled at edge N produces the result on the outputs after edge N. One register stage; no combinational path from `address` to outputs.
- Throughput: a new address every cycle. No handshake; the input is always accepted.
- Reset asserted mid-stream forces the outputs to 0 within the same cycle. The first post-release edge registers the current `address`.
- Address jumps (e.g. 47999 → 0) are handled like any other address, with no internal state.

## Configuration
- `AUDIO_LUT_FADE_EN` defined: linear fade-out over the last 256 samples.
  - For `CLIP_LENGTH`−256 ≤ a < `CLIP_LENGTH`: output = (S · (`CLIP_LENGTH`−a)) >>> 8.
  - The product is computed as signed 25-bit with an arithmetic shift, and the result truncated to 16 bits.
  - Latency remains 1 cycle.
- `AUDIO_LUT_FADE_EN` undefined: no fade. The last 256 samples equal the plain sine values and no multiplier is synthesised.

## Test plan
- Reset: hold `rst_n` = 0 with `address` = 16 → `data_out` = 0x0000, `out_of_range` = 0. Release, one edge → `data_out` = 32000 (0x7D00).
- Segment 0 sweep, addresses 0, 8, 16, 48 on consecutive cycles → outputs one cycle later: 0, 22627, 32000, −32000 (0x8300). Verify full-period symmetry S(p) = −S(p+32) for p in 0..31.
- Segment 1 and 2 peaks:
  - Address 16008 → 32000; 16024 → −32000.
  - Address 32004 → 32000; 32012 → −32000.
  - Address 15999 vs 16000: phase continuity check, 16000 → 0.
- Range and wrap: address 47999 → in-range sample, `out_of_range` = 0. Address 48000 → 0, `out_of_range` = 1. Address 65535 → 0, `out_of_range` = 1. Then address 0 → 0, `out_of_range` = 0.
- Fade: address 47748 → 31500 with `AUDIO_LUT_FADE_EN` defined, 32000 without. Address 47744 → identical in both builds.
- Mid-stream reset: stream addresses 0..100, pulse `rst_n` low between edges → outputs go to 0 asynchronously. After release, the first output matches the address presented at that edge.
